// File: rtl/rat_io_hub.sv
// Port-mapped I/O hub for the RAT MCU: strobed output registers, synchronised
// input channels and a change-detect interrupt block with mask/pending/source.
module rat_io_hub #(
  parameter int         NUM_OUT    = 4,
  parameter int         NUM_IN     = 4,
  parameter logic [7:0] OUT_BASE   = 8'h40,
  parameter logic [7:0] IN_BASE    = 8'h90,
  parameter logic [7:0] IRQ_BASE   = 8'hF0,
  parameter bit         PULSE_MODE = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [7:0]           PORT_ID,
  input  logic [7:0]           OUT_PORT,
  input  logic                 IO_STRB,
  output logic [7:0]           IN_PORT,
  input  logic [8*NUM_IN-1:0]  IN_DATA,
  output logic [8*NUM_OUT-1:0] OUT_DATA,
  output logic [NUM_OUT-1:0]   OUT_WSTB,
  output logic                 INTR
);

  localparam int OUT_LO = int'(OUT_BASE);
  localparam int OUT_HI = OUT_LO + NUM_OUT - 1;
  localparam int IN_LO  = int'(IN_BASE);
  localparam int IN_HI  = IN_LO + NUM_IN - 1;
  localparam int IRQ_LO = int'(IRQ_BASE);
  localparam int IRQ_HI = IRQ_LO + 2;

  localparam logic [7:0] IN_CH_BITS = 8'((1 << NUM_IN) - 1);

  function automatic bit ranges_overlap(input int a_lo, input int a_hi,
                                        input int b_lo, input int b_hi);
    return (a_lo <= b_hi) && (b_lo <= a_hi);
  endfunction

  // Configuration sanity: a bad map must stop elaboration, not alias silently.
  generate
    if (NUM_OUT < 1 || NUM_OUT > 8 || NUM_IN < 1 || NUM_IN > 8) begin : g_bad_count
      $error("rat_io_hub: NUM_OUT and NUM_IN must be in 1..8");
    end
    if (OUT_HI > 255 || IN_HI > 255 || IRQ_HI > 255) begin : g_bad_range
      $error("rat_io_hub: an address range runs past 8'hFF");
    end
    if (ranges_overlap(OUT_LO, OUT_HI, IN_LO, IN_HI) ||
        ranges_overlap(OUT_LO, OUT_HI, IRQ_LO, IRQ_HI) ||
        ranges_overlap(IN_LO, IN_HI, IRQ_LO, IRQ_HI)) begin : g_overlap
      $error("rat_io_hub: address ranges overlap");
    end
  endgenerate

  logic [8*NUM_OUT-1:0] out_data_q, out_data_d;
  logic [NUM_OUT-1:0]   wstb_q, wstb_d;
  logic [8*NUM_IN-1:0]  sync1_q, sync1_d;
  logic [8*NUM_IN-1:0]  sync2_q, sync2_d;
  logic [8*NUM_IN-1:0]  prev_q, prev_d;
  logic [1:0]           arm_cnt_q, arm_cnt_d;
  logic [7:0]           mask_q, mask_d;
  logic [7:0]           pend_q, pend_d;
  logic                 agg_q, agg_d;
  logic                 agg_dly_q, agg_dly_d;

  logic                 armed;
  logic                 wr_mask;
  logic                 wr_pend;
  logic [7:0]           pend_set;
  logic [7:0]           pend_clr;
  logic [7:0]           pend_masked;
  logic                 src_valid;
  logic [2:0]           src_idx;
  logic [7:0]           src;
  logic [7:0]           rd_data;

  // IO_STRB is a single-cycle write qualifier; there is no back-pressure.
  always_comb begin
    wr_mask = IO_STRB && (PORT_ID == IRQ_BASE);
    wr_pend = IO_STRB && (PORT_ID == IRQ_BASE + 8'd1);
  end

  always_comb begin
    out_data_d = out_data_q;
    wstb_d     = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (IO_STRB && (PORT_ID == OUT_BASE + 8'(i))) begin
        out_data_d[8*i +: 8] = OUT_PORT;
        wstb_d[i]            = 1'b1;
      end
    end
  end

  // Arm counter holds off change detection until sync2/prev carry real samples.
  always_comb begin
    sync1_d   = IN_DATA;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    armed     = (arm_cnt_q == 2'd3);
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
  end

  always_comb begin
    pend_set = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      pend_set[i] = armed && (sync2_q[8*i +: 8] != prev_q[8*i +: 8]);
    end
    pend_clr = wr_pend ? OUT_PORT : 8'h00;
    // Set is OR-ed after the clear so a same-cycle event is never lost.
    pend_d   = (pend_q & ~pend_clr) | pend_set;
    mask_d   = wr_mask ? (OUT_PORT & IN_CH_BITS) : mask_q;
  end

  always_comb begin
    pend_masked = pend_q & mask_q;
    src_valid   = 1'b0;
    src_idx     = 3'd0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (pend_masked[i]) begin
        src_valid = 1'b1;
        src_idx   = 3'(i);
      end
    end
    src       = {src_valid, 4'b0000, src_idx};
    agg_d     = |pend_masked;
    agg_dly_d = agg_q;
  end

  // Later assignments override earlier ones: IRQ regs > inputs > outputs.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (PORT_ID == OUT_BASE + 8'(i)) rd_data = out_data_q[8*i +: 8];
    end
    for (int i = 0; i < NUM_IN; i++) begin
      if (PORT_ID == IN_BASE + 8'(i)) rd_data = sync2_q[8*i +: 8];
    end
    if (PORT_ID == IRQ_BASE) begin
      rd_data = mask_q;
    end else if (PORT_ID == IRQ_BASE + 8'd1) begin
      rd_data = pend_q;
    end else if (PORT_ID == IRQ_BASE + 8'd2) begin
      rd_data = src;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_data_q <= '0;
      wstb_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      arm_cnt_q  <= 2'd0;
      mask_q     <= 8'h00;
      pend_q     <= 8'h00;
      agg_q      <= 1'b0;
      agg_dly_q  <= 1'b0;
    end else begin
      out_data_q <= out_data_d;
      wstb_q     <= wstb_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      arm_cnt_q  <= arm_cnt_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      agg_q      <= agg_d;
      agg_dly_q  <= agg_dly_d;
    end
  end

  always_comb begin
    IN_PORT  = rd_data;
    OUT_DATA = out_data_q;
    OUT_WSTB = wstb_q;
    INTR     = PULSE_MODE ? (agg_q & ~agg_dly_q) : agg_q;
  end

endmodule

// File: tb/tb_rat_io_hub.sv
// Bench for rat_io_hub: directed scenarios plus random traffic scored against
// a delay-line reference model; a level-mode and a pulse-mode instance share stimulus.
module tb_rat_io_hub;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  port_id;
  logic [7:0]  out_port;
  logic        io_strb;
  logic [31:0] in_data;
  logic [7:0]  in_port, in_port_p;
  logic [31:0] out_data, out_data_p;
  logic [3:0]  out_wstb, out_wstb_p;
  logic        intr, intr_p;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rat_io_hub #(.PULSE_MODE(1'b0)) dut (
    .CLK(clk), .RESET(rst), .PORT_ID(port_id), .OUT_PORT(out_port),
    .IO_STRB(io_strb), .IN_PORT(in_port), .IN_DATA(in_data),
    .OUT_DATA(out_data), .OUT_WSTB(out_wstb), .INTR(intr)
  );

  rat_io_hub #(.PULSE_MODE(1'b1)) dut_p (
    .CLK(clk), .RESET(rst), .PORT_ID(port_id), .OUT_PORT(out_port),
    .IO_STRB(io_strb), .IN_PORT(in_port_p), .IN_DATA(in_data),
    .OUT_DATA(out_data_p), .OUT_WSTB(out_wstb_p), .INTR(intr_p)
  );

  // Reference model: m_hist[k] = IN_DATA word sampled k+1 edges ago.
  logic [31:0] m_hist [3] = '{32'h0, 32'h0, 32'h0};
  int          m_since_rst = 0;
  logic [31:0] m_out = '0;
  logic [3:0]  m_wstb = '0;
  logic [7:0]  m_mask = '0;
  logic [7:0]  m_pend = '0;
  logic        m_agg1 = 1'b0;
  logic        m_agg2 = 1'b0;

  function automatic logic [7:0] model_src();
    logic [7:0] pm;
    pm = m_pend & m_mask;
    for (int i = 0; i < 8; i++) begin
      if (pm[i]) return {1'b1, 4'b0000, 3'(i)};
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    if (a == 8'hF0) return m_mask;
    if (a == 8'hF1) return m_pend;
    if (a == 8'hF2) return model_src();
    if (a >= 8'h90 && a <= 8'h93) return m_hist[1][8*int'(a - 8'h90) +: 8];
    if (a >= 8'h40 && a <= 8'h43) return m_out[8*int'(a - 8'h40) +: 8];
    return 8'h00;
  endfunction

  task automatic tick();
    logic [31:0] n_hist0, n_hist1, n_hist2, n_out;
    logic [3:0]  n_wstb;
    logic [7:0]  n_mask, n_pend, set_v, clr_v;
    logic        n_agg1, n_agg2;
    int          n_since;
    if (rst) begin
      n_hist0 = '0; n_hist1 = '0; n_hist2 = '0;
      n_out = '0; n_wstb = '0; n_mask = '0; n_pend = '0;
      n_agg1 = 1'b0; n_agg2 = 1'b0; n_since = 0;
    end else begin
      set_v = '0;
      if (m_since_rst >= 3) begin
        for (int c = 0; c < 4; c++) begin
          if (m_hist[1][8*c +: 8] != m_hist[2][8*c +: 8]) set_v[c] = 1'b1;
        end
      end
      clr_v  = (io_strb && port_id == 8'hF1) ? out_port : 8'h00;
      n_pend = (m_pend & ~clr_v) | set_v;
      n_mask = (io_strb && port_id == 8'hF0) ? (out_port & 8'h0F) : m_mask;
      n_out  = m_out;
      n_wstb = '0;
      for (int c = 0; c < 4; c++) begin
        if (io_strb && port_id == 8'h40 + 8'(c)) begin
          n_out[8*c +: 8] = out_port;
          n_wstb[c]       = 1'b1;
        end
      end
      n_agg1  = |(m_pend & m_mask);
      n_agg2  = m_agg1;
      n_hist0 = in_data;
      n_hist1 = m_hist[0];
      n_hist2 = m_hist[1];
      n_since = (m_since_rst < 3) ? m_since_rst + 1 : 3;
    end
    @(posedge clk);
    #1;
    m_hist[0] = n_hist0; m_hist[1] = n_hist1; m_hist[2] = n_hist2;
    m_out = n_out; m_wstb = n_wstb; m_mask = n_mask; m_pend = n_pend;
    m_agg1 = n_agg1; m_agg2 = n_agg2; m_since_rst = n_since;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    port_id = a;
    #1;
    d = in_port;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id  = a;
    out_port = d;
    io_strb  = 1'b1;
    tick();
    io_strb  = 1'b0;
    port_id  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1; io_strb = 1'b0; port_id = 8'h90; out_port = 8'h00;
    in_data = 32'h000000A5;
    tick(); tick();
    n_checks++; if (out_data !== 32'h0) begin n_errors++; $display("FAIL rst_out_data: got %h want %h", out_data, 32'h0); end
    n_checks++; if (out_wstb !== 4'h0) begin n_errors++; $display("FAIL rst_wstb: got %b want %b", out_wstb, 4'h0); end
    n_checks++; if (intr !== 1'b0 || intr_p !== 1'b0) begin n_errors++; $display("FAIL rst_intr: got %b/%b want 0/0", intr, intr_p); end
    n_checks++; if (in_port !== 8'h00) begin n_errors++; $display("FAIL rst_in_port: got %h want %h", in_port, 8'h00); end
    rst = 1'b0;
    tick();
    n_checks++; if (in_port !== 8'h00) begin n_errors++; $display("FAIL in_lat1: got %h want %h", in_port, 8'h00); end
    tick();
    n_checks++; if (in_port !== 8'hA5) begin n_errors++; $display("FAIL in_lat2: got %h want %h", in_port, 8'hA5); end
    begin
      logic [7:0] d;
      repeat (4) tick();
      rd(8'hF1, d);
      n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL rst_no_false_pend: got %h want %h", d, 8'h00); end
    end
  endtask

  task automatic test_out_write();
    logic [7:0] d;
    wr(8'h42, 8'h3C);
    n_checks++; if (out_data !== 32'h003C0000) begin n_errors++; $display("FAIL wr_data: got %h want %h", out_data, 32'h003C0000); end
    n_checks++; if (out_wstb !== 4'b0100) begin n_errors++; $display("FAIL wr_wstb: got %b want %b", out_wstb, 4'b0100); end
    tick();
    n_checks++; if (out_wstb !== 4'b0000) begin n_errors++; $display("FAIL wr_wstb_drop: got %b want %b", out_wstb, 4'b0000); end
    rd(8'h42, d);
    n_checks++; if (d !== 8'h3C) begin n_errors++; $display("FAIL wr_readback: got %h want %h", d, 8'h3C); end
    wr(8'h44, 8'h5A);
    n_checks++; if (out_data !== 32'h003C0000 || out_wstb !== 4'b0000) begin n_errors++; $display("FAIL wr_unmapped: got %h/%b want %h/%b", out_data, out_wstb, 32'h003C0000, 4'b0000); end
    wr(8'h90, 8'h77);
    wr(8'hF2, 8'hFF);
    rd(8'hF0, d);
    n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL wr_src_ignored_mask: got %h want %h", d, 8'h00); end
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL wr_src_ignored_pend: got %h want %h", d, 8'h00); end
    n_checks++; if (out_data !== 32'h003C0000) begin n_errors++; $display("FAIL wr_input_ignored: got %h want %h", out_data, 32'h003C0000); end
  endtask

  task automatic test_back_to_back();
    port_id = 8'h41; out_port = 8'h11; io_strb = 1'b1;
    tick();
    n_checks++; if (out_wstb !== 4'b0010 || out_data[15:8] !== 8'h11) begin n_errors++; $display("FAIL b2b_first: got %b/%h want 0010/11", out_wstb, out_data[15:8]); end
    out_port = 8'h22;
    tick();
    n_checks++; if (out_wstb !== 4'b0010 || out_data[15:8] !== 8'h22) begin n_errors++; $display("FAIL b2b_second: got %b/%h want 0010/22", out_wstb, out_data[15:8]); end
    io_strb = 1'b0; port_id = 8'h00;
    tick();
    n_checks++; if (out_wstb !== 4'b0000 || out_data[15:8] !== 8'h22) begin n_errors++; $display("FAIL b2b_end: got %b/%h want 0000/22", out_wstb, out_data[15:8]); end
  endtask

  task automatic test_irq_level();
    logic [7:0] d;
    wr(8'hF0, 8'h05);
    in_data = 32'h007700A5;
    tick(); tick();
    rd(8'h92, d);
    n_checks++; if (d !== 8'h77) begin n_errors++; $display("FAIL lvl_in_vis: got %h want %h", d, 8'h77); end
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL lvl_pend_early: got %h want %h", d, 8'h00); end
    tick();
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h04 || intr !== 1'b0) begin n_errors++; $display("FAIL lvl_pend_lat3: got %h/%b want 04/0", d, intr); end
    tick();
    n_checks++; if (intr !== 1'b1) begin n_errors++; $display("FAIL lvl_intr_lat4: got %b want 1", intr); end
    in_data = 32'h0077005A;
    repeat (4) tick();
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h05) begin n_errors++; $display("FAIL lvl_pend05: got %h want %h", d, 8'h05); end
    rd(8'hF2, d);
    n_checks++; if (d !== 8'h80 || intr !== 1'b1) begin n_errors++; $display("FAIL lvl_src80: got %h/%b want 80/1", d, intr); end
    wr(8'hF1, 8'h01);
    rd(8'hF2, d);
    n_checks++; if (d !== 8'h82) begin n_errors++; $display("FAIL lvl_src82: got %h want %h", d, 8'h82); end
    tick();
    n_checks++; if (intr !== 1'b1) begin n_errors++; $display("FAIL lvl_intr_held: got %b want 1", intr); end
    wr(8'hF1, 8'h04);
    n_checks++; if (intr !== 1'b1) begin n_errors++; $display("FAIL lvl_intr_clr_edge_n: got %b want 1", intr); end
    tick();
    n_checks++; if (intr !== 1'b0) begin n_errors++; $display("FAIL lvl_intr_clr_edge_n1: got %b want 0", intr); end
    rd(8'hF2, d);
    n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL lvl_src_empty: got %h want %h", d, 8'h00); end
  endtask

  task automatic test_masked();
    logic [7:0] d;
    wr(8'hF0, 8'h00);
    in_data = 32'h0077335A;
    repeat (4) tick();
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h02 || intr !== 1'b0) begin n_errors++; $display("FAIL msk_pend: got %h/%b want 02/0", d, intr); end
    wr(8'hF0, 8'h02);
    n_checks++; if (intr !== 1'b0) begin n_errors++; $display("FAIL msk_unmask_edge: got %b want 0", intr); end
    tick();
    n_checks++; if (intr !== 1'b1) begin n_errors++; $display("FAIL msk_unmask_raise: got %b want 1", intr); end
    wr(8'hF0, 8'h00);
    tick();
    rd(8'hF1, d);
    n_checks++; if (intr !== 1'b0 || d !== 8'h02) begin n_errors++; $display("FAIL msk_remask: got %b/%h want 0/02", intr, d); end
    wr(8'hF1, 8'hFF);
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL msk_clear_all: got %h want %h", d, 8'h00); end
  endtask

  task automatic test_pulse();
    logic [7:0] d;
    int pulses;
    wr(8'hF0, 8'h08);
    tick();
    n_checks++; if (intr_p !== 1'b0) begin n_errors++; $display("FAIL pls_idle: got %b want 0", intr_p); end
    pulses = 0;
    in_data = 32'h1177335A;
    for (int k = 1; k <= 12; k++) begin
      if (k == 4) in_data = 32'h2277335A;
      tick();
      if (intr_p === 1'b1) pulses++;
      if (k == 4) begin
        n_checks++; if (intr_p !== 1'b1) begin n_errors++; $display("FAIL pls_rise: got %b want 1", intr_p); end
      end
      if (k == 5) begin
        n_checks++; if (intr_p !== 1'b0) begin n_errors++; $display("FAIL pls_width: got %b want 0", intr_p); end
      end
    end
    n_checks++; if (pulses != 1) begin n_errors++; $display("FAIL pls_count: got %0d want 1", pulses); end
    rd(8'hF1, d);
    n_checks++; if (intr !== 1'b1 || d !== 8'h08) begin n_errors++; $display("FAIL pls_level_ref: got %b/%h want 1/08", intr, d); end
    wr(8'hF0, 8'h00);
    tick(); tick();
    wr(8'hF0, 8'h08);
    n_checks++; if (intr_p !== 1'b0) begin n_errors++; $display("FAIL pls_unmask_edge: got %b want 0", intr_p); end
    tick();
    n_checks++; if (intr_p !== 1'b1) begin n_errors++; $display("FAIL pls_unmask_pulse: got %b want 1", intr_p); end
    tick();
    n_checks++; if (intr_p !== 1'b0) begin n_errors++; $display("FAIL pls_unmask_end: got %b want 0", intr_p); end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    wr(8'hF1, 8'hFF);
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL col_pre: got %h want %h", d, 8'h00); end
    in_data = 32'h227733A0;
    tick(); tick();
    wr(8'hF1, 8'h01);
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h01) begin n_errors++; $display("FAIL col_set_wins: got %h want %h", d, 8'h01); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    wr(8'hF0, 8'h01);
    tick();
    n_checks++; if (intr !== 1'b1) begin n_errors++; $display("FAIL rmid_pre_intr: got %b want 1", intr); end
    rst = 1'b1; io_strb = 1'b1; port_id = 8'h40; out_port = 8'h99;
    in_data = 32'h227733A1;
    tick();
    rst = 1'b0; io_strb = 1'b0; port_id = 8'h00;
    n_checks++; if (out_data !== 32'h0 || out_wstb !== 4'h0 || intr !== 1'b0) begin n_errors++; $display("FAIL rmid_discard: got %h/%b/%b want 0/0/0", out_data, out_wstb, intr); end
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL rmid_pend_lost: got %h want %h", d, 8'h00); end
    tick();
    in_data = 32'h227744A1;
    tick(); tick();
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h00) begin n_errors++; $display("FAIL arm_suppress: got %h want %h", d, 8'h00); end
    tick();
    rd(8'hF1, d);
    n_checks++; if (d !== 8'h02) begin n_errors++; $display("FAIL arm_detect: got %h want %h", d, 8'h02); end
  endtask

  task automatic test_random();
    logic [7:0] exp_rd;
    int sel;
    for (int it = 0; it < 400; it++) begin
      rst     = ($urandom_range(0, 63) == 0);
      io_strb = 1'($urandom_range(0, 1));
      sel     = $urandom_range(0, 5);
      case (sel)
        0:       port_id = 8'h40 + 8'($urandom_range(0, 4));
        1:       port_id = 8'h90 + 8'($urandom_range(0, 3));
        2:       port_id = 8'hF0 + 8'($urandom_range(0, 2));
        3:       port_id = 8'($urandom);
        4:       port_id = 8'hF1;
        default: port_id = 8'hF0;
      endcase
      out_port = 8'($urandom);
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 7) == 0) in_data[8*c +: 8] = 8'($urandom);
      end
      #1;
      exp_rd = model_rd(port_id);
      n_checks++; if (in_port !== exp_rd || in_port_p !== exp_rd) begin n_errors++; $display("FAIL rnd_read it=%0d id=%h: got %h/%h want %h", it, port_id, in_port, in_port_p, exp_rd); end
      tick();
      n_checks++; if (out_data !== m_out || out_wstb !== m_wstb) begin n_errors++; $display("FAIL rnd_out it=%0d: got %h/%b want %h/%b", it, out_data, out_wstb, m_out, m_wstb); end
      n_checks++; if (intr !== m_agg1 || intr_p !== (m_agg1 & ~m_agg2)) begin n_errors++; $display("FAIL rnd_intr it=%0d: got %b/%b want %b/%b", it, intr, intr_p, m_agg1, m_agg1 & ~m_agg2); end
    end
    rst = 1'b0; io_strb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_out_write();
    test_back_to_back();
    test_irq_level();
    test_masked();
    test_pulse();
    test_collision();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
